// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the execute stage and the data
// memory port. It checks funct3 legality and alignment, drives a word-aligned
// request with byte enables and lane-replicated store data, holds the request
// until mem_ack, and returns extended load data or an error.
// Optional feature macro: LSU_TIMEOUT_EN (abandon a request after TIMEOUT_CYC
// cycles without mem_ack and report an error).
module lsu_mem_master #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                  state, state_nxt;
   logic                    we_p1;
   logic [2:0]              funct3_p1;
   logic [ADDR_WIDTH-1:0]   addr_p1;
   logic [DATA_WIDTH-1:0]   wdata_p1;
   logic [DATA_WIDTH-1:0]   rdata_p2;
   logic                    err_p2;
   logic                    req_ok;
   logic                    tmo_hit;

   // Loads accept b/h/w/bu/hu; stores only b/h/w.
   function automatic logic legal_f(input logic we, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: legal_f = 1'b1;
         3'b100, 3'b101:         legal_f = ~we;
         default:                legal_f = 1'b0;
      endcase
   endfunction

   function automatic logic aligned_f(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   aligned_f = ~off[0];
         2'b10:   aligned_f = (off == 2'b00);
         default: aligned_f = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   be_f = 4'b0001 << off;
         2'b01:   be_f = off[1] ? 4'b1100 : 4'b0011;
         default: be_f = 4'b1111;
      endcase
   endfunction

   // Replicate the store datum across every lane it may land on.
   function automatic logic [DATA_WIDTH-1:0] wdata_f(input logic [2:0] f3,
                                                     input logic [DATA_WIDTH-1:0] wd);
      case (f3[1:0])
         2'b00:   wdata_f = {4{wd[7:0]}};
         2'b01:   wdata_f = {2{wd[15:0]}};
         default: wdata_f = wd;
      endcase
   endfunction

   // Pick the addressed lane and sign- or zero-extend it (funct3[2] = unsigned).
   function automatic logic [DATA_WIDTH-1:0] load_ext_f(input logic [2:0] f3,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rd);
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      b_s = rd[{off, 3'b000} +: 8];
      h_s = off[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  load_ext_f = {{24{b_s[7]}}, b_s};
         3'b100:  load_ext_f = {24'd0, b_s};
         3'b001:  load_ext_f = {{16{h_s[15]}}, h_s};
         3'b101:  load_ext_f = {16'd0, h_s};
         default: load_ext_f = rd;
      endcase
   endfunction

   assign req_ok = legal_f(req_we, req_funct3) & aligned_f(req_funct3, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt;

   // Wait counter: held at zero outside REQ, counts REQ cycles without an ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                tmo_cnt <= '0;
      else if (state != REQ)  tmo_cnt <= '0;
      else if (!mem_ack)      tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Fires in the TIMEOUT_CYC-th REQ cycle, so mem_req is high that many cycles.
   assign tmo_hit = (state == REQ) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register; the async reset drops mem_req immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; an ack in the timeout cycle still completes normally.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = req_ok ? REQ : RESP;
         REQ:     if (mem_ack || tmo_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the request on acceptance and the response on ack/timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_p1     <= 1'b0;
         funct3_p1 <= 3'b000;
         addr_p1   <= '0;
         wdata_p1  <= '0;
         rdata_p2  <= '0;
         err_p2    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_p1     <= req_we;
               funct3_p1 <= req_funct3;
               addr_p1   <= req_addr;
               wdata_p1  <= req_wdata;
               rdata_p2  <= '0;
               err_p2    <= ~req_ok;
            end
            REQ: if (mem_ack) begin
               rdata_p2 <= we_p1 ? '0 : load_ext_f(funct3_p1, addr_p1[1:0], mem_rdata);
               err_p2   <= 1'b0;
            end else if (tmo_hit) begin
               rdata_p2 <= '0;
               err_p2   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign mem_req   = (state == REQ);
   assign mem_we    = mem_req & we_p1;
   assign mem_addr  = mem_req ? {addr_p1[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_be    = mem_req ? be_f(funct3_p1, addr_p1[1:0]) : 4'b0000;
   assign mem_wdata = mem_we ? wdata_f(funct3_p1, wdata_p1) : '0;
   assign rsp_valid = (state == RESP);
   assign rsp_err   = rsp_valid & err_p2;
   assign rsp_rdata = rsp_valid ? rdata_p2 : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: directed and randomized load/store transactions
// compared against a byte-lane reference model.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata, last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_err;

   lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---- reference model ----
   function automatic bit m_legal(input bit we, input bit [2:0] f3);
      if (we) return f3 inside {3'd0, 3'd1, 3'd2};
      return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   endfunction

   function automatic int m_size(input bit [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic bit m_ok(input bit we, input bit [2:0] f3, input bit [31:0] a);
      if (!m_legal(we, f3)) return 1'b0;
      return (a % m_size(f3)) == 0;
   endfunction

   function automatic bit [3:0] m_be(input bit [2:0] f3, input bit [31:0] a);
      bit [3:0] be = 4'b0;
      int off = int'(a % 4);
      int sz = m_size(f3);
      for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) be[i] = 1'b1;
      return be;
   endfunction

   function automatic bit [31:0] m_mask(input int sz);
      if (sz == 4) return 32'hFFFF_FFFF;
      return (32'd1 << (8 * sz)) - 32'd1;
   endfunction

   function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] wd);
      int sz = m_size(f3);
      bit [31:0] v = wd & m_mask(sz);
      bit [31:0] r = 32'd0;
      for (int k = 0; k < 4 / sz; k++) r = r | (v << (8 * sz * k));
      return r;
   endfunction

   function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
      int sz = m_size(f3);
      int off = int'(a % 4);
      bit [31:0] v = (rd >> (8 * off)) & m_mask(sz);
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   // One complete transaction: present, hold for dly cycles, ack, check response.
   task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, input int dly, input bit [31:0] rd);
      bit ok = m_ok(we, f3, a);
      @(negedge clk);
      chk("ready_idle", req_ready, 1);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      req_valid = 0; mem_ack = 0;
      req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (!ok) begin
         chk("err_rsp_valid", rsp_valid, 1);
         chk("err_rsp_err", rsp_err, 1);
         chk("err_rdata", rsp_rdata, 0);
         chk("err_no_memreq", mem_req, 0);
         last_err = rsp_err;
         last_rdata = rsp_rdata;
      end else begin
         chk("mem_req", mem_req, 1);
         chk("ready_busy", req_ready, 0);
         chk("mem_we", mem_we, we);
         chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
         chk("mem_be", mem_be, m_be(f3, a));
         if (we) chk("mem_wdata", mem_wdata, m_wdata(f3, wd));
         last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("mem_req_hold", mem_req, 1);
            chk("mem_addr_hold", mem_addr, a & 32'hFFFF_FFFC);
            chk("no_rsp_wait", rsp_valid, 0);
         end
         mem_ack = 1; mem_rdata = rd;
         @(negedge clk);
         mem_ack = 0; mem_rdata = $urandom;
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_err", rsp_err, 0);
         chk("rsp_rdata", rsp_rdata, we ? 32'd0 : m_load(f3, a, rd));
         chk("memreq_drop", mem_req, 0);
         last_err = rsp_err;
         last_rdata = rsp_rdata;
      end
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("ready_back", req_ready, 1);
   endtask

   initial begin
      int acc[$];
      int hi;
      rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      last_rdata = 0; last_addr = 0; last_wdata = 0; last_be = 0; last_err = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
      rst = 0;

      // directed accesses
      txn(1, 3'b010, 32'h8, 32'hDEADBEEF, 2, 32'h0);
      chk("t1_addr", last_addr, 32'h8);
      chk("t1_be", last_be, 4'b1111);
      chk("t1_wdata", last_wdata, 32'hDEADBEEF);
      txn(0, 3'b000, 32'h13, 32'h0, 0, 32'h80FF1234);
      chk("t2_be", last_be, 4'b1000);
      chk("t2_lb", last_rdata, 32'hFFFFFF80);
      txn(0, 3'b100, 32'h13, 32'h0, 1, 32'h80FF1234);
      chk("t2_lbu", last_rdata, 32'h00000080);
      txn(1, 3'b001, 32'h6, 32'h0000ABCD, 0, 32'h0);
      chk("t3_addr", last_addr, 32'h4);
      chk("t3_be", last_be, 4'b1100);
      chk("t3_wdata", last_wdata, 32'hABCDABCD);
      txn(0, 3'b101, 32'h6, 32'h0, 0, 32'hABCD0000);
      chk("t3_lhu", last_rdata, 32'h0000ABCD);
      txn(0, 3'b010, 32'h2, 32'h0, 0, 32'h0);
      chk("t4_lw_mis", last_err, 1);
      txn(1, 3'b001, 32'h1, 32'h0, 0, 32'h0);
      chk("t4_sh_mis", last_err, 1);
      txn(1, 3'b100, 32'h0, 32'h0, 0, 32'h0);
      chk("t4_st_f3", last_err, 1);

      // randomized accesses
      for (int n = 0; n < 300; n++) begin
         bit [31:0] a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         txn(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 3)), $urandom);
      end

      // back-to-back with immediate acks
      @(negedge clk);
      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100; mem_ack = 1;
      for (int i = 0; i < 30; i++) begin
         if (req_ready) acc.push_back(i);
         if (mem_req || rsp_valid) chk("b2b_ready_low", req_ready, 0);
         @(negedge clk);
      end
      req_valid = 0; mem_ack = 0;
      chk("b2b_count", acc.size(), 10);
      for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], 3);
      repeat (3) @(negedge clk);

      // reset in the middle of a request
      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h40;
      @(negedge clk);
      req_valid = 0;
      chk("rstreq_memreq", mem_req, 1);
      #2 rst = 1;
      #1 chk("rstreq_drop", mem_req, 0);
      @(negedge clk);
      rst = 0; mem_ack = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ack = 0;
         chk("rstreq_no_rsp", rsp_valid, 0);
         chk("rstreq_no_memreq", mem_req, 0);
      end

      // ack never arrives
      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h80;
      @(negedge clk);
      req_valid = 0;
      hi = 0;
`ifdef LSU_TIMEOUT_EN
      for (int i = 0; i < 20 && mem_req; i++) begin
         hi++;
         @(negedge clk);
      end
      chk("tmo_len", hi, 4);
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_rsp_err", rsp_err, 1);
      chk("tmo_rdata", rsp_rdata, 0);
`else
      for (int i = 0; i < 1000; i++) begin
         if (mem_req) hi++;
         @(negedge clk);
      end
      chk("notmo_hold", hi, 1000);
      chk("notmo_no_rsp", rsp_valid, 0);
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_ack = 0;
      chk("notmo_rsp_valid", rsp_valid, 1);
      chk("notmo_rdata", rsp_rdata, 32'h1234_5678);
`endif
      @(negedge clk);
      chk("final_ready", req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
